// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store responder for the core's data port.
// One request is accepted at a time over valid/ready. The request is served
// from an internal word-wide synchronous RAM, and the result comes back as a
// single-cycle response pulse.
// Supports byte, halfword and word accesses with little-endian lanes and
// sign/zero extension on loads. Sub-word stores use read-modify-write.
// Optional feature: define DATA_MEM_CTRL_ALIGN_CHECK_EN to reject misaligned
// half/word accesses with resp_err instead of silently aligning them.
module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IdxW  = ADDR_WIDTH - 2;
  localparam int Words = 2 ** IdxW;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t r_state;

  // Request captured at accept; later input changes must not affect the op.
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [1:0]      r_lane;
  logic [IdxW-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;

  // RAM array, its registered read port, and the merged word for RMW.
  logic [DATA_WIDTH-1:0] r_mem [Words];
  logic [DATA_WIDTH-1:0] r_ramQ;
  logic [DATA_WIDTH-1:0] r_merged;

  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_wordStore;
  logic [IdxW-1:0]       w_inIdx;
  logic [1:0]            w_inLane;
  logic                  w_ramWe;
  logic [IdxW-1:0]       w_ramWaddr;
  logic [DATA_WIDTH-1:0] w_ramWdata;
  logic                  w_unused;

  // Address bits above the decoded range are ignored, so addresses wrap.
  assign w_unused = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_inIdx   = req_addr[ADDR_WIDTH-1:2];

`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
  assign w_misalign = ((req_size == SizeHalf) && req_addr[0]) ||
                      ((req_size == SizeWord) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err       = (req_size == SizeRsvd) || w_misalign;
  assign w_wordStore = req_we && (req_size == SizeWord) && !w_err;

  // Effective lane after alignment: halves keep only addr[1], words use lane 0.
  always_comb begin
    w_inLane = req_addr[1:0];
    if (req_size == SizeHalf) begin
      w_inLane = {req_addr[1], 1'b0};
    end else if (req_size == SizeWord) begin
      w_inLane = 2'b00;
    end
  end

  // Select the single RAM write: a word store at accept or the merge write-back.
  always_comb begin
    w_ramWe    = 1'b0;
    w_ramWaddr = w_inIdx;
    w_ramWdata = req_wdata;
    if (w_accept && w_wordStore) begin
      w_ramWe = 1'b1;
    end else if ((r_state == MERGE) && rst_n) begin
      w_ramWe    = 1'b1;
      w_ramWaddr = r_idx;
      w_ramWdata = r_merged;
    end
  end

  // Extract the addressed lane(s) and extend to the full data width.
  function automatic logic [DATA_WIDTH-1:0] extendLoad(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_WIDTH-1:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SizeByte: res = uns ? {{(DATA_WIDTH-8){1'b0}}, b}
                          : {{(DATA_WIDTH-8){b[7]}}, b};
      SizeHalf: res = uns ? {{(DATA_WIDTH-16){1'b0}}, h}
                          : {{(DATA_WIDTH-16){h[15]}}, h};
      default:  res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old word with the store data low bytes.
  function automatic logic [DATA_WIDTH-1:0] mergeStore(
    input logic [DATA_WIDTH-1:0] word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [1:0]            lane,
    input logic [1:0]            size
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    if (size == SizeByte) begin
      case (lane)
        2'd0:    res[7:0]   = wdata[7:0];
        2'd1:    res[15:8]  = wdata[7:0];
        2'd2:    res[23:16] = wdata[7:0];
        default: res[31:24] = wdata[7:0];
      endcase
    end else if (size == SizeHalf) begin
      if (lane[1]) begin
        res[31:16] = wdata[15:0];
      end else begin
        res[15:0] = wdata[15:0];
      end
    end else begin
      res = wdata;
    end
    return res;
  endfunction

  // RAM write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_mem[w_ramWaddr] <= w_ramWdata;
    end
    if (w_accept && !w_err) begin
      r_ramQ <= r_mem[w_inIdx];
    end
  end

  // Control FSM with registered response outputs and request capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= w_inLane;
            r_idx      <= w_inIdx;
            r_wdata    <= req_wdata;
            if (w_err) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (w_wordStore) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          if (!r_we) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= extendLoad(r_ramQ, r_lane, r_size, r_unsigned);
            resp_err   <= 1'b0;
          end else begin
            r_merged <= mergeStore(r_ramQ, r_wdata, r_lane, r_size);
            r_state  <= MERGE;
          end
        end
        MERGE: begin
          r_state    <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed testbench for data_mem_ctrl.
// Expectations follow DATA_MEM_CTRL_ALIGN_CHECK_EN when it is defined.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;

  int testsRun;
  int testsFailed;

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (reqValid),
    .req_ready    (reqReady),
    .req_we       (reqWe),
    .req_size     (reqSize),
    .req_unsigned (reqUnsigned),
    .req_addr     (reqAddr),
    .req_wdata    (reqWdata),
    .resp_valid   (respValid),
    .resp_rdata   (respRdata),
    .resp_err     (respErr)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one request, then report latency (edges from accept, 1 = E0+1),
  // response data/error and the time of the accept edge. lat = -1 on timeout.
  task automatic applyStimulus(input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat,
                               output logic [31:0] rdata, output logic err,
                               output time acceptTime);
    int waitCnt;
    lat = -1;
    rdata = 'x;
    err = 1'bx;
    acceptTime = 0;
    waitCnt = 0;
    @(negedge clk);
    while (!reqReady && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!reqReady) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ready_timeout: req_ready got 0 want 1");
      return;
    end
    reqValid = 1'b1;
    reqWe = we;
    reqSize = size;
    reqUnsigned = uns;
    reqAddr = addr;
    reqWdata = wdata;
    @(posedge clk);
    acceptTime = $time;
    #1;
    reqValid = 1'b0;
    reqWe = ~we;
    reqSize = ~size;
    reqUnsigned = ~uns;
    reqAddr = 32'h0000_0ABC;
    reqWdata = 32'h5A5A_5A5A;
    for (int n = 0; n < 10; n++) begin
      if (respValid) begin
        lat = n + 1;
        rdata = respRdata;
        err = respErr;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (reqReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b want 0", reqReady);
    end
    testsRun++;
    if (respValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_valid: got %b want 0", respValid);
    end
    testsRun++;
    if (respRdata !== 32'h0 || respErr !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: rdata %h err %b want 0 0", respRdata, respErr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (reqReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL release_ready: got %b want 1", reqReady);
    end
  endtask

  task automatic test_word_access();
    int lat;
    logic [31:0] rd;
    logic er;
    time t;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er, t);
    testsRun++;
    if (lat !== 1 || er !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wstore: lat %0d err %b want 1 0", lat, er);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (respValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_pulse: resp_valid got %b want 0", respValid);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, t);
    testsRun++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wload: lat %0d data %h err %b want 2 deadbeef 0", lat, rd, er);
    end
  endtask

  task automatic test_byte_access();
    int lat;
    logic [31:0] rd;
    logic er;
    time t;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h102, 32'hAAAA557F, lat, rd, er, t);
    testsRun++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL bstore: lat %0d err %b data %h want 3 0 0", lat, er, rd);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'hDE7FBEEF) begin
      testsFailed++;
      $display("[TB] FAIL bstore_merge: got %h want de7fbeef", rd);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er, t);
    testsRun++;
    if (lat !== 2 || rd !== 32'hFFFFFFDE) begin
      testsFailed++;
      $display("[TB] FAIL bload_signed: lat %0d data %h want 2 ffffffde", lat, rd);
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'h000000DE) begin
      testsFailed++;
      $display("[TB] FAIL bload_unsigned: got %h want 000000de", rd);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'h0000007F) begin
      testsFailed++;
      $display("[TB] FAIL bload_lane2: got %h want 0000007f", rd);
    end
  endtask

  task automatic test_half_access();
    int lat;
    logic [31:0] rd;
    logic er;
    time t;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'h80001234, lat, rd, er, t);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat, rd, er, t);
    testsRun++;
    if (lat !== 2 || rd !== 32'h00001234) begin
      testsFailed++;
      $display("[TB] FAIL hload_low: lat %0d data %h want 2 00001234", lat, rd);
    end
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'hFFFF8000) begin
      testsFailed++;
      $display("[TB] FAIL hload_high_signed: got %h want ffff8000", rd);
    end
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'h00008000) begin
      testsFailed++;
      $display("[TB] FAIL hload_high_unsigned: got %h want 00008000", rd);
    end
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h300, 32'h11111111, lat, rd, er, t);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234CAFE, lat, rd, er, t);
    testsRun++;
    if (lat !== 3 || er !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hstore: lat %0d err %b want 3 0", lat, er);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'hCAFE1111) begin
      testsFailed++;
      $display("[TB] FAIL hstore_merge: got %h want cafe1111", rd);
    end
  endtask

  task automatic test_misaligned();
    int lat;
    logic [31:0] rd;
    logic er;
    time t;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, lat, rd, er, t);
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    testsRun++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL misaligned_wload: lat %0d err %b data %h want 1 1 0", lat, er, rd);
    end
`else
    testsRun++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h80001234) begin
      testsFailed++;
      $display("[TB] FAIL misaligned_wload: lat %0d err %b data %h want 2 0 80001234", lat, er, rd);
    end
`endif
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h304, 32'h55667788, lat, rd, er, t);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h305, 32'h01020304, lat, rd, er, t);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, lat, rd, er, t);
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    testsRun++;
    if (rd !== 32'h55667788) begin
      testsFailed++;
      $display("[TB] FAIL misaligned_wstore: got %h want 55667788", rd);
    end
`else
    testsRun++;
    if (rd !== 32'h01020304) begin
      testsFailed++;
      $display("[TB] FAIL misaligned_wstore: got %h want 01020304", rd);
    end
`endif
  endtask

  task automatic test_reserved_size();
    int lat;
    logic [31:0] rd;
    logic er;
    time t;
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, rd, er, t);
    testsRun++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_load: lat %0d err %b data %h want 1 1 0", lat, er, rd);
    end
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, lat, rd, er, t);
    testsRun++;
    if (er !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_store_err: got %b want 1", er);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'h80001234) begin
      testsFailed++;
      $display("[TB] FAIL rsvd_no_write: got %h want 80001234", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    logic er;
    time t0;
    time t1;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h400, 32'hAAAA0001, lat, rd, er, t0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h404, 32'hBBBB0002, lat, rd, er, t1);
    testsRun++;
    if ((t1 - t0) !== 20) begin
      testsFailed++;
      $display("[TB] FAIL b2b_spacing: got %0t want 20", t1 - t0);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, lat, rd, er, t0);
    testsRun++;
    if (rd !== 32'hAAAA0001) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: got %h want aaaa0001", rd);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, lat, rd, er, t0);
    testsRun++;
    if (rd !== 32'hBBBB0002) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: got %h want bbbb0002", rd);
    end
  endtask

  task automatic test_addr_wrap();
    int lat;
    logic [31:0] rd;
    logic er;
    time t;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h1100, 32'hA5A5A5A5, lat, rd, er, t);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'hA5A5A5A5) begin
      testsFailed++;
      $display("[TB] FAIL addr_wrap: got %h want a5a5a5a5", rd);
    end
  endtask

  task automatic test_reset_mid_merge();
    int lat;
    logic [31:0] rd;
    logic er;
    time t;
    logic sawValid;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, lat, rd, er, t);
    @(negedge clk);
    while (!reqReady) @(negedge clk);
    reqValid = 1'b1;
    reqWe = 1'b1;
    reqSize = 2'b00;
    reqUnsigned = 1'b0;
    reqAddr = 32'h200;
    reqWdata = 32'h000000FF;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if (respValid !== 1'b0 || reqReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_edge: valid %b ready %b want 0 0", respValid, reqReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (respValid) sawValid = 1'b1;
    end
    testsRun++;
    if (sawValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_no_resp: saw resp_valid %b want 0", sawValid);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, er, t);
    testsRun++;
    if (rd !== 32'h11223344) begin
      testsFailed++;
      $display("[TB] FAIL midreset_ram: got %h want 11223344", rd);
    end
  endtask

  // Main sequence.
  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    reqValid = 1'b0;
    reqWe = 1'b0;
    reqSize = 2'b00;
    reqUnsigned = 1'b0;
    reqAddr = 32'h0;
    reqWdata = 32'h0;
    test_reset();
    test_word_access();
    test_byte_access();
    test_half_access();
    test_misaligned();
    test_reserved_size();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid_merge();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
